// File: rtl/ascii_case_pkg.sv
// Shared constants for the ASCII case-conversion stream: mode codes,
// letter bounds and the skid-buffer state encoding.
package ascii_case_pkg;

    localparam logic [1:0] MODE_PASS   = 2'b00;
    localparam logic [1:0] MODE_UPPER  = 2'b01;
    localparam logic [1:0] MODE_LOWER  = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    localparam logic [7:0] UC_LO = 8'h41;
    localparam logic [7:0] UC_HI = 8'h5A;
    localparam logic [7:0] LC_LO = 8'h61;
    localparam logic [7:0] LC_HI = 8'h7A;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_TWO   = 2'b10
    } skid_state_e;

endpackage

// File: rtl/case_lane_conv.sv
// Single-byte case converter: letters get bit5 adjusted by mode, everything
// else passes; a masked-off lane yields 0x00 and never reports a change.
module case_lane_conv
    import ascii_case_pkg::*;
(
    input  logic [7:0] ch,
    input  logic [1:0] mode,
    input  logic       keep,
    output logic [7:0] conv,
    output logic       changed
);

    logic is_uc;
    logic is_lc;
    logic flip;

    always_comb begin
        is_uc = (ch >= UC_LO) && (ch <= UC_HI);
        is_lc = (ch >= LC_LO) && (ch <= LC_HI);
        flip  = 1'b0;
        case (mode)
            MODE_UPPER:  flip = is_lc;
            MODE_LOWER:  flip = is_uc;
            MODE_TOGGLE: flip = is_uc | is_lc;
            default:     flip = 1'b0;
        endcase
        conv    = keep ? (ch ^ {2'b00, flip, 5'b00000}) : 8'h00;
        changed = keep & flip;
    end

endmodule

// File: rtl/ascii_case_stream.sv
// Multi-lane ASCII case converter with valid/ready handshake, a registered
// two-entry skid buffer and a saturating count of bytes actually changed.
module ascii_case_stream
    import ascii_case_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [LANES-1:0]     in_keep,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [LANES-1:0]     out_keep,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 cnt_clear,
    output logic [CNT_W-1:0]     conv_count
);

    localparam int DW   = 8 * LANES;
    localparam int PC_W = $clog2(LANES + 1);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [CNT_W+PC_W-1:0] sum;
        sum = {{PC_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
        if (sum > {{PC_W{1'b0}}, {CNT_W{1'b1}}})
            return {CNT_W{1'b1}};
        return sum[CNT_W-1:0];
    endfunction

    logic [DW-1:0]    conv_data;
    logic [LANES-1:0] lane_chg;
    logic [PC_W-1:0]  n_chg;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        case_lane_conv u_lane (
            .ch      (in_data[8*i +: 8]),
            .mode    (mode),
            .keep    (in_keep[i]),
            .conv    (conv_data[8*i +: 8]),
            .changed (lane_chg[i])
        );
    end

    always_comb begin
        n_chg = '0;
        for (int i = 0; i < LANES; i++)
            n_chg = n_chg + PC_W'(lane_chg[i]);
    end

    // Acceptance stage: converted beat lands in the output register or skid slot
    skid_state_e      state;
    logic [DW-1:0]    skid_data;
    logic [LANES-1:0] skid_keep;
    logic             skid_last;
    logic             accept;
    logic             pop;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SKID_EMPTY;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            out_last   <= 1'b0;
            conv_count <= '0;
        end else begin
            if (cnt_clear)
                conv_count <= '0;
            else if (accept)
                conv_count <= sat_add(conv_count, n_chg);

            case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        out_data  <= conv_data;
                        out_keep  <= in_keep;
                        out_last  <= in_last;
                        out_valid <= 1'b1;
                        state     <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && !pop) begin
                        skid_data <= conv_data;
                        skid_keep <= in_keep;
                        skid_last <= in_last;
                        in_ready  <= 1'b0;
                        state     <= SKID_TWO;
                    end else if (pop && !accept) begin
                        out_valid <= 1'b0;
                        state     <= SKID_EMPTY;
                    end else if (accept && pop) begin
                        out_data <= conv_data;
                        out_keep <= in_keep;
                        out_last <= in_last;
                    end
                end
                SKID_TWO: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop) begin
                        out_data <= skid_data;
                        out_keep <= skid_keep;
                        out_last <= skid_last;
                        in_ready <= 1'b1;
                        state    <= SKID_ONE;
                    end
                end
                default: begin
                    state     <= SKID_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_case_stream.sv
// Bench for ascii_case_stream: directed steps plus randomized traffic checked
// against a queue-based reference; a second instance with a 4-bit counter.
module tb_ascii_case_stream;

    localparam int LANES = 4;
    localparam int DW    = 8 * LANES;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic [DW-1:0]    in_data;
    logic [LANES-1:0] in_keep;
    logic             in_last;
    logic             in_valid;
    logic             out_ready;
    logic             cnt_clear;

    logic             in_ready,  in_ready4;
    logic [DW-1:0]    out_data,  out_data4;
    logic [LANES-1:0] out_keep,  out_keep4;
    logic             out_last,  out_last4;
    logic             out_valid, out_valid4;
    logic [15:0]      conv_count;
    logic [3:0]       conv_count4;

    always #5 clk = ~clk;

    ascii_case_stream #(.LANES(LANES), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .cnt_clear(cnt_clear), .conv_count(conv_count)
    );

    ascii_case_stream #(.LANES(LANES), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .mode(mode),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready4),
        .out_data(out_data4), .out_keep(out_keep4), .out_last(out_last4),
        .out_valid(out_valid4), .out_ready(out_ready),
        .cnt_clear(cnt_clear), .conv_count(conv_count4)
    );

    typedef struct {
        logic [DW-1:0]    d;
        logic [LANES-1:0] k;
        logic             l;
    } beat_t;

    beat_t q[$];
    int    total;
    bit    last_acc;
    int    n_checks;
    int    n_pass;
    int    n_fail;

    // Character-level reference: letters shift by 32 between cases
    function automatic logic [7:0] ref_byte(input logic [7:0] c, input logic [1:0] m);
        int  v;
        bit  up;
        bit  lo;
        v  = int'(c);
        up = (v >= 65) && (v <= 90);
        lo = (v >= 97) && (v <= 122);
        case (m)
            2'd1: if (lo) v = v - 32;
            2'd2: if (up) v = v + 32;
            2'd3: begin
                if (up) v = v + 32;
                else if (lo) v = v - 32;
            end
            default: ;
        endcase
        return v[7:0];
    endfunction

    task automatic ref_beat(output beat_t b, output int nchg);
        logic [7:0] c;
        logic [7:0] r;
        nchg = 0;
        b.k  = in_keep;
        b.l  = in_last;
        b.d  = '0;
        for (int i = 0; i < LANES; i++) begin
            c = in_data[8*i +: 8];
            r = ref_byte(c, mode);
            if (in_keep[i]) begin
                b.d[8*i +: 8] = r;
                if (r != c) nchg++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input logic [LANES-1:0] k,
                         input bit l, input logic [1:0] m, input bit ordy, input bit clr);
        in_valid  = v;
        in_data   = d;
        in_keep   = k;
        in_last   = l;
        mode      = m;
        out_ready = ordy;
        cnt_clear = clr;
    endtask

    task automatic tick();
        bit    acc;
        bit    pop;
        beat_t b;
        beat_t dropped;
        int    nchg;
        @(posedge clk);
        acc = in_valid && (q.size() < 2) && !rst;
        pop = (q.size() > 0) && out_ready;
        if (rst) begin
            q.delete();
            total = 0;
            acc   = 1'b0;
        end else begin
            ref_beat(b, nchg);
            if (pop) dropped = q.pop_front();
            if (acc) q.push_back(b);
            if (cnt_clear) total = 0;
            else if (acc) total += nchg;
        end
        last_acc = acc;
        #1;
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready4", 64'(in_ready4), 64'(q.size() < 2));
        chk("out_valid4", 64'(out_valid4), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(q[0].d));
            chk("out_keep", 64'(out_keep), 64'(q[0].k));
            chk("out_last", 64'(out_last), 64'(q[0].l));
            chk("out_data4", 64'(out_data4), 64'(q[0].d));
            chk("out_keep4", 64'(out_keep4), 64'(q[0].k));
            chk("out_last4", 64'(out_last4), 64'(q[0].l));
        end
        chk("conv_count", 64'(conv_count), 64'((total > 65535) ? 65535 : total));
        chk("conv_count4", 64'(conv_count4), 64'((total > 15) ? 15 : total));
    endtask

    function automatic logic [DW-1:0] rand_text();
        logic [DW-1:0] d;
        for (int i = 0; i < LANES; i++) begin
            if ($urandom_range(0, 3) == 0) d[8*i +: 8] = 8'($urandom_range(0, 255));
            else d[8*i +: 8] = 8'($urandom_range(8'h40, 8'h7B));
        end
        return d;
    endfunction

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0; total = 0; last_acc = 1'b0;
        rst = 1'b1;
        drive(0, '0, '0, 0, 2'd0, 1, 0);
        tick();
        tick();
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_out_keep", 64'(out_keep), 64'h0);
        chk("rst_out_last", 64'(out_last), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_count", 64'(conv_count), 64'h0);
        rst = 1'b0;

        drive(1, 32'h7A61205A, 4'hF, 0, 2'd1, 1, 0);
        tick();
        chk("upper_data", 64'(out_data), 64'h5A41205A);
        chk("upper_count", 64'(conv_count), 64'd2);

        drive(1, 32'h40617B5B, 4'hF, 0, 2'd3, 1, 0);
        tick();
        chk("toggle_data", 64'(out_data), 64'h40417B5B);
        chk("toggle_count", 64'(conv_count), 64'd3);

        drive(1, 32'h2020E1C1, 4'hF, 1, 2'd2, 1, 0);
        tick();
        chk("lower_high_data", 64'(out_data), 64'h2020E1C1);
        chk("lower_last", 64'(out_last), 64'h1);
        chk("lower_count", 64'(conv_count), 64'd3);

        drive(1, 32'h61616161, 4'b0101, 0, 2'd1, 1, 0);
        tick();
        chk("keep_data", 64'(out_data), 64'h00410041);
        chk("keep_keep", 64'(out_keep), 64'h5);
        chk("keep_count", 64'(conv_count), 64'd5);

        drive(0, '0, '0, 0, 2'd0, 1, 0);
        tick();

        // Backpressure: two beats fill the buffer, the third waits
        drive(1, 32'h61626364, 4'hF, 0, 2'd1, 0, 0);
        tick();
        drive(1, 32'h65666768, 4'hF, 0, 2'd1, 0, 0);
        tick();
        chk("bp_full_ready", 64'(in_ready), 64'h0);
        drive(1, 32'h696A6B6C, 4'hF, 1, 2'd1, 0, 0);
        repeat (3) tick();
        chk("bp_hold_data", 64'(out_data), 64'h41424344);
        out_ready = 1'b1;
        last_acc  = 1'b0;
        for (int i = 0; i < 8 && !last_acc; i++) tick();
        chk("bp_third_accepted", 64'(last_acc), 64'h1);
        drive(0, '0, '0, 0, 2'd0, 1, 0);
        repeat (3) tick();
        chk("bp_ready_back", 64'(in_ready), 64'h1);

        // Randomized traffic; a beat is held until accepted
        for (int n = 0; n < 600; n++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = rand_text();
                in_keep  = 4'($urandom_range(0, 15));
                in_last  = 1'($urandom_range(0, 1));
                mode     = 2'($urandom_range(0, 3));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clear = ($urandom_range(0, 40) == 0);
            tick();
        end

        // Saturation of the 4-bit counter and clear priority
        drive(0, '0, '0, 0, 2'd0, 1, 1);
        tick();
        drive(1, 32'h61626364, 4'hF, 0, 2'd1, 1, 0);
        repeat (5) tick();
        chk("sat_count4", 64'(conv_count4), 64'd15);
        chk("sat_count16", 64'(conv_count), 64'd20);
        drive(1, 32'h61626364, 4'hF, 0, 2'd1, 1, 1);
        tick();
        chk("clr_prio", 64'(conv_count), 64'd0);
        chk("clr_prio4", 64'(conv_count4), 64'd0);
        drive(0, '0, '0, 0, 2'd0, 1, 0);
        repeat (2) tick();

        // Reset with two beats buffered
        drive(1, 32'h61616161, 4'hF, 0, 2'd1, 0, 0);
        tick();
        drive(1, 32'h62626262, 4'hF, 1, 2'd1, 0, 0);
        tick();
        chk("mid_full", 64'(in_ready), 64'h0);
        rst = 1'b1;
        drive(0, '0, '0, 0, 2'd0, 0, 0);
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(out_valid), 64'h0);
        chk("mid_rst_ready", 64'(in_ready), 64'h1);
        chk("mid_rst_count", 64'(conv_count), 64'h0);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("no_stale_beat", 64'(out_valid), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ascii_case_stream.md
Name: ascii_case_stream

Overview:
- Streaming, parametrised successor to the single-byte combinational uppercase converter.
- Converts LANES ASCII bytes per beat under a runtime-selectable mode: pass, upper, lower or toggle.
- Uses a valid/ready handshake, a registered 2-entry skid buffer, per-lane keep mask, frame-last passthrough and a saturating converted-character counter.
- Sits between the byte-stream source (UART RX / text FIFO) and downstream text consumers.

Parameters:
- LANES, 4, bytes per beat (1..16); data width = 8*LANES, lane i = bits [8i+7:8i].
- CNT_W, 16, width of the converted-character counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- mode  input  2  00 pass, 01 upper, 10 lower, 11 toggle; sampled with each accepted beat.
- in_data  input  8*LANES  input bytes.
- in_keep  input  LANES  lane valid mask.
- in_last  input  1  end-of-frame marker.
- in_valid  input  1  source has a beat.
- in_ready  output  1  block can accept a beat (registered).
- out_data  output  8*LANES  converted bytes.
- out_keep  output  LANES  forwarded keep.
- out_last  output  1  forwarded last.
- out_valid  output  1  output beat present.
- out_ready  input  1  sink accepts.
- cnt_clear  input  1  synchronous clear of conv_count.
- conv_count  output  CNT_W  number of bytes actually changed; saturating.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge): in_ready=1, out_valid=0, out_data=0, out_keep=0, out_last=0, conv_count=0, skid buffer empty.
  - Reset mid-frame discards all held beats.
  - No output beat is produced after reset until a new beat is accepted.
- Handshake:
  - A beat transfers on an input or output edge where valid&&ready.
  - out_valid stays high and out_data/keep/last stay stable until out_ready.
  - in_valid may be asserted independently of in_ready.
- Per-lane conversion, combinational, applied at acceptance:
  - Letters are 0x41..0x5A and 0x61..0x7A only.
  - upper: clear bit5 of lowercase letters. lower: set bit5 of uppercase letters. toggle: flip bit5 of any letter. pass: no change.
  - All non-letters, including 0x80..0xFF, 0x40, 0x5B, 0x60 and 0x7B, pass unchanged.
  - Lanes with keep=0 output 0x00 and are never counted.
- Latency and throughput:
  - Accepted beat appears on out_* at the next edge (1 cycle) when the buffer is empty.
  - Full throughput of 1 beat/cycle while out_ready=1.
- Skid buffer FSM, states EMPTY / ONE / TWO:
  - EMPTY: accept -> ONE.
  - ONE: accept without pop -> TWO; pop without accept -> EMPTY; accept and pop -> ONE.
  - TWO: pop -> ONE; accept impossible.
  - in_ready = (state != TWO), registered; it deasserts the edge the second entry is written.
  - Output always presents the oldest entry; ordering is preserved.
- Mode: a mode change applies only to beats accepted at or after the edge where the new value is sampled. Buffered beats keep their conversion.
- conv_count:
  - On each accepted beat, adds popcount of lanes whose output byte differs from input.
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clear has priority over an increment in the same cycle: result is 0.
  - rst overrides everything.
- last is carried unmodified with its beat. Beats with in_keep=0 are still forwarded.

Decomposition:
- Package ascii_case_pkg:
  - Mode constants MODE_PASS/UPPER/LOWER/TOGGLE (2-bit).
  - Letter bound constants 0x41/0x5A/0x61/0x7A.
  - Skid state encoding.
- Sub-module case_lane_conv: one combinational byte converter (byte, mode, keep -> byte, changed flag), instantiated LANES times via generate.
- Top level holds the skid FSM and counter.

Test Plan:
- Reset then upper, LANES=4, in_data=0x7A61205A ('z','a',' ','Z'), keep=1111, out_ready=1 -> next cycle out_data=0x5A41205A, out_valid=1, conv_count=2.
- Toggle, in_data=0x4061_7B5B, keep=1111 -> out_data=0x4041_7B5B, conv_count+=1; boundary bytes unchanged. lower with 0xE1C1 in low lanes -> unchanged.
- keep=0101, upper, in_data=0x61616161 -> out_data=0x00410041, out_keep=0101, count+=2.
- Backpressure: out_ready=0, present 3 beats -> in_ready low after 2 accepted, third held. Then out_ready=1 -> beats emerge in order with stable data, and in_ready reasserts.
- Saturation (CNT_W=4): 5 beats of 4 lowercase under upper -> conv_count=15. cnt_clear with a simultaneous convertible beat -> conv_count=0.
- Reset mid-frame with 2 beats buffered -> out_valid=0, in_ready=1, conv_count=0 next cycle; no stale beat emitted afterwards.
